// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs decoded RV32I fields (opcode, registers, funct3 and a
//                32-bit byte-offset immediate) into an instruction word,
//                range-checks the immediate for its format, and queues the
//                result in a small output FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      imm_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      instr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] count_o,
    output logic [7:0]       err_cnt_o
);

    localparam int               ADDR_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  c_FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [31:0]      c_NOP      = 32'h0000_0013;
    localparam logic [6:0]       c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0]       c_OP_JALR  = 7'b1100111;
    localparam logic [6:0]       c_OP_IMM   = 7'b0010011;
    localparam logic [6:0]       c_OP_STORE = 7'b0100011;
    localparam logic [6:0]       c_OP_BR    = 7'b1100011;
    localparam logic [6:0]       c_OP_LUI   = 7'b0110111;
    localparam logic [6:0]       c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0]       c_OP_JAL   = 7'b1101111;

    logic [31:0]       w_enc;
    logic              w_err;
    logic              w_imm12_ok;
    logic              w_imm13_ok;
    logic              w_imm21_ok;
    logic              w_push;
    logic              w_pop;

    logic [32:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_occ;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_err_cnt;

    // Sign-extension checks: the upper immediate bits must all equal the
    // format's sign bit for the value to be representable.
    assign w_imm12_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign w_imm13_ok = ((imm_i[31:12] == '0) || (imm_i[31:12] == '1)) && !imm_i[0];
    assign w_imm21_ok = ((imm_i[31:20] == '0) || (imm_i[31:20] == '1)) && !imm_i[0];

    // Scatter the immediate into the format selected by the opcode; any
    // failure substitutes a NOP and flags the entry.
    always_comb begin
        w_enc = c_NOP;
        w_err = 1'b0;
        case (opcode_i)
            c_OP_LOAD, c_OP_JALR, c_OP_IMM: begin
                if (w_imm12_ok) w_enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                else            w_err = 1'b1;
            end
            c_OP_STORE: begin
                if (w_imm12_ok) w_enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                else            w_err = 1'b1;
            end
            c_OP_BR: begin
                if (w_imm13_ok) w_enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                         imm_i[4:1], imm_i[11], opcode_i};
                else            w_err = 1'b1;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                if (imm_i[11:0] == '0) w_enc = {imm_i[31:12], rd_i, opcode_i};
                else                   w_err = 1'b1;
            end
            c_OP_JAL: begin
                if (w_imm21_ok) w_enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                                         rd_i, opcode_i};
                else            w_err = 1'b1;
            end
            default: w_err = 1'b1;
        endcase
    end

    // Full/empty come straight from the registered occupancy, so ready_o
    // never depends on ready_i in the same cycle.
    assign ready_o   = (r_occ != c_FULL);
    assign valid_o   = (r_occ != '0);
    assign w_push    = valid_i && ready_o;
    assign w_pop     = valid_o && ready_i;
    assign instr_o   = valid_o ? r_mem[r_rptr][31:0] : 32'h0;
    assign err_o     = valid_o ? r_mem[r_rptr][32]   : 1'b0;
    assign count_o   = r_count;
    assign err_cnt_o = r_err_cnt;

    // Storage array; contents need no reset because outputs are gated by valid_o.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= {w_err, w_enc};
    end

    // Pointers, occupancy and statistics counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr  <= r_wptr + ADDR_W'(1);
                r_count <= r_count + CNT_W'(1);
                if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_pop) r_rptr <= r_rptr + ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (ADDR_W+1)'(1);
                2'b01:   r_occ <= r_occ - (ADDR_W+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder: directed vectors plus
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [6:0]       opcode_i = '0;
    logic [4:0]       rd_i = '0;
    logic [4:0]       rs1_i = '0;
    logic [4:0]       rs2_i = '0;
    logic [2:0]       funct3_i = '0;
    logic [31:0]      imm_i = '0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [31:0]      instr_o;
    logic             err_o;
    logic [CNT_W-1:0] count_o;
    logic [7:0]       err_cnt_o;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .err_o(err_o), .count_o(count_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    entry_t      exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned m_count  = 0;
    int unsigned m_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoder: range rules as signed arithmetic, fields placed by shifting.
    function automatic entry_t ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [31:0] imm);
        entry_t      e;
        int          s;
        bit          ok;
        logic [31:0] w, o, d, a, b, f;
        s = int'($signed(imm));
        o = 32'(op); d = 32'(rd) << 7; a = 32'(rs1) << 15; b = 32'(rs2) << 20; f = 32'(f3) << 12;
        ok = 1'b0; w = 32'h0;
        case (op)
            7'b0000011, 7'b1100111, 7'b0010011: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = ((imm & 32'hFFF) << 20) | a | f | d | o;
            end
            7'b0100011: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (((imm >> 5) & 32'h7F) << 25) | b | a | f | ((imm & 32'h1F) << 7) | o;
            end
            7'b1100011: begin
                ok = (s >= -4096) && (s <= 4094) && ((imm & 32'h1) == 0);
                w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | b | a | f |
                     (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
            end
            7'b0110111, 7'b0010111: begin
                ok = (imm % 4096) == 0;
                w  = (imm & 32'hFFFF_F000) | d | o;
            end
            7'b1101111: begin
                ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && ((imm & 32'h1) == 0);
                w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                     (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
            end
            default: ok = 1'b0;
        endcase
        e.instr = ok ? w : 32'h0000_0013;
        e.err   = !ok;
        return e;
    endfunction

    // One clock: update the model with what fires at the coming edge, then
    // check every observable output 1 ns after the edge.
    task automatic step();
        bit pin, pout;
        pin  = valid_i && ready_o;
        pout = valid_o && ready_i;
        if (pout) begin
            if (exp_q.size() == 0) chk("pop_on_empty", 32'd1, 32'd0);
            else void'(exp_q.pop_front());
        end
        if (pin) begin
            entry_t e;
            e = ref_encode(opcode_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i);
            exp_q.push_back(e);
            m_count = (m_count + 1) % (1 << CNT_W);
            if (e.err && m_errs < 255) m_errs++;
        end
        @(posedge clk_i); #1;
        chk("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
        chk("ready_o", 32'(ready_o), 32'(exp_q.size() < DEPTH));
        if (exp_q.size() != 0) begin
            chk("instr_o", instr_o, exp_q[0].instr);
            chk("err_o", 32'(err_o), 32'(exp_q[0].err));
        end
        chk("count_o", 32'(count_o), m_count);
        chk("err_cnt_o", 32'(err_cnt_o), m_errs);
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        valid_i = 1'b1; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; imm_i = imm;
    endtask

    task automatic do_reset();
        valid_i = 1'b0; ready_i = 1'b0; rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_q.delete(); m_count = 0; m_errs = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_instr_o", instr_o, 32'h0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_count_o", 32'(count_o), 32'd0);
        chk("rst_err_cnt_o", 32'(err_cnt_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // ADDI x1, x0, 5: visible one cycle after accept
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        step();
        valid_i = 1'b0;
        chk("addi_instr", instr_o, 32'h0050_0093);
        chk("addi_err", 32'(err_o), 32'd0);
        chk("addi_count", 32'(count_o), 32'd1);
        ready_i = 1'b1;
        step();

        // LW then SW back-to-back, draining in order
        drive(7'b0000011, 5'd2, 5'd1, 5'd0, 3'b010, 32'd8);
        step();
        chk("lw_instr", instr_o, 32'h0080_A103);
        drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd12);
        step();
        chk("sw_instr", instr_o, 32'h0020_A623);
        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
        step();
        chk("beq_instr", instr_o, 32'hFE20_8EE3);
        drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
        step();
        chk("jal_instr", instr_o, 32'h0010_00EF);
        drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        step();
        chk("lui_instr", instr_o, 32'h1234_52B7);
        valid_i = 1'b0;
        step();

        // Three error entries from a clean start
        do_reset();
        ready_i = 1'b1;
        drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001);
        step();
        chk("err_lui_instr", instr_o, 32'h0000_0013);
        chk("err_lui_flag", 32'(err_o), 32'd1);
        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        step();
        chk("err_beq_flag", 32'(err_o), 32'd1);
        drive(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0);
        step();
        chk("err_op_flag", 32'(err_o), 32'd1);
        valid_i = 1'b0;
        step();
        chk("err_cnt_3", 32'(err_cnt_o), 32'd3);
        chk("count_3", 32'(count_o), 32'd3);

        // Backpressure: fill past capacity, then drain
        ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive(7'b0010011, 5'(i + 1), 5'd3, 5'd0, 3'd0, 32'(i * 7));
            step();
        end
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        valid_i = 1'b0; ready_i = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();

        // Asynchronous reset between edges with entries queued
        ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(7'b0010011, 5'd9, 5'd9, 5'd0, 3'd0, 32'(i + 100));
            step();
        end
        valid_i = 1'b0;
        #3 rst_i = 1'b1;
        #1;
        chk("arst_valid_o", 32'(valid_o), 32'd0);
        chk("arst_count_o", 32'(count_o), 32'd0);
        chk("arst_ready_o", 32'(ready_o), 32'd1);
        #3 rst_i = 1'b0;
        exp_q.delete(); m_count = 0; m_errs = 0;
        @(posedge clk_i); #1;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        step();
        chk("post_arst_instr", instr_o, 32'h0050_0093);
        valid_i = 1'b0; ready_i = 1'b1;
        step();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [6:0]  op;
            logic [31:0] imm;
            case ($urandom_range(0, 9))
                0: op = 7'b0000011;  1: op = 7'b1100111;  2: op = 7'b0010011;
                3: op = 7'b0100011;  4: op = 7'b1100011;  5: op = 7'b0110111;
                6: op = 7'b0010111;  7: op = 7'b1101111;  8: op = 7'b1101111;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: imm = $urandom;
                2: imm = $urandom & 32'hFFFF_F000;
                default: imm = 32'($urandom_range(0, 32'h20_0000)) - 32'h10_0000;
            endcase
            valid_i  = ($urandom_range(0, 3) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
            opcode_i = op; imm_i = imm;
            rd_i = 5'($urandom); rs1_i = 5'($urandom); rs2_i = 5'($urandom);
            funct3_i = 3'($urandom);
            step();
        end

        // Error counter saturation
        ready_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
            step();
        end
        chk("err_cnt_sat", 32'(err_cnt_o), 32'd255);
        valid_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) step();
        chk("final_empty", 32'(valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
